// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_pkg
//  Purpose  : Shared CPU definitions for the HI/LO multiply-divide unit:
//             HI/LO op encoding, writeback-select encoding, FSM states,
//             iteration count and a signed-magnitude helper.
//  Revision : 1.0 - initial release
// ============================================================================
package hilo_muldiv_pkg;

   // One shift-add or restoring-divide step per result bit
   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = 5;

   // Op select presented to the HI/LO unit; 6 and 7 are reserved no-ops
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } hilo_op_e;

   // Writeback selector encoding; HI_reg/LO_reg feed the WB_HI/WB_LO legs
   typedef enum logic [2:0] {
      WB_ALU = 3'd0,
      WB_MEM = 3'd1,
      WB_PC8 = 3'd2,
      WB_HI  = 3'd3,
      WB_LO  = 3'd4
   } wb_sel_e;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } muldiv_state_e;

   // Absolute value of a 32-bit operand when treated as signed; raw otherwise.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv
//  Purpose  : Iterative 32x32 multiply / 64/32 divide unit owning the
//             architectural HI and LO registers. Multiply and divide share
//             one 64-bit accumulator and one 5-bit iteration counter.
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv
   import hilo_muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  Op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] HI_reg,
   output logic [31:0] LO_reg
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

   muldiv_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        is_mul_q, is_mul_d;       // 1: multiply, 0: divide
   logic        res_neg_q, res_neg_d;     // negate product / quotient in FIN
   logic        rem_neg_q, rem_neg_d;     // negate remainder in FIN
   logic        div_zero_q, div_zero_d;   // divisor was zero
   logic [31:0] rs_raw_q, rs_raw_d;       // unmodified dividend for divide-by-zero
   logic [31:0] opb_q, opb_d;             // multiplicand or divisor magnitude
   logic [63:0] acc_q, acc_d;             // {hi half, lo half} working register
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        start_mul;
   logic        start_signed;
   logic [31:0] rs_mag;
   logic [31:0] rt_mag;
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] div_step;
   logic [63:0] prod_neg;

   assign start_mul    = (Op == OP_MULT) || (Op == OP_MULTU);
   assign start_signed = (Op == OP_MULT) || (Op == OP_DIV);
   assign rs_mag       = magnitude(rs_data, start_signed);
   assign rt_mag       = magnitude(rt_data, start_signed);

   // Shift-add: add multiplicand into the upper half when the multiplier LSB
   // is set, then shift the whole 65-bit result right by one.
   assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
   assign mul_step = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

   // Restoring divide: the partial remainder shifted left with the next
   // dividend bit needs 33 bits; a borrow out of bit 32 means "restore".
   assign div_shift = acc_q[63:31];
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_step  = div_diff[32] ? {acc_q[62:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};

   assign prod_neg = 64'd0 - acc_q;

   // Next-state, datapath and HI/LO update logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_mul_d   = is_mul_q;
      res_neg_d  = res_neg_q;
      rem_neg_d  = rem_neg_q;
      div_zero_d = div_zero_q;
      rs_raw_d   = rs_raw_q;
      opb_d      = opb_q;
      acc_d      = acc_q;
      hi_d       = hi_q;
      lo_d       = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (Op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d    = ST_RUN;
                     cnt_d      = '0;
                     is_mul_d   = start_mul;
                     res_neg_d  = start_signed && (rs_data[31] ^ rt_data[31]);
                     rem_neg_d  = start_signed && rs_data[31];
                     div_zero_d = (rt_data == 32'd0);
                     rs_raw_d   = rs_data;
                     if (start_mul) begin
                        opb_d = rs_mag;
                        acc_d = {32'd0, rt_mag};
                     end else begin
                        opb_d = rt_mag;
                        acc_d = {32'd0, rs_mag};
                     end
                  end
                  OP_MTHI: hi_d = rs_data;
                  OP_MTLO: lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            acc_d = is_mul_q ? mul_step : div_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            if (is_mul_q) begin
               {hi_d, lo_d} = res_neg_q ? prod_neg : acc_q;
            end else if (div_zero_q) begin
               hi_d = rs_raw_q;
               lo_d = 32'hFFFF_FFFF;
            end else begin
               lo_d = res_neg_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
               hi_d = rem_neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any operation without touching HI/LO beyond clearing
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_mul_q   <= 1'b0;
         res_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         rs_raw_q   <= '0;
         opb_q      <= '0;
         acc_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_mul_q   <= is_mul_d;
         res_neg_q  <= res_neg_d;
         rem_neg_q  <= rem_neg_d;
         div_zero_q <= div_zero_d;
         rs_raw_q   <= rs_raw_d;
         opb_q      <= opb_d;
         acc_q      <= acc_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign HI_reg = hi_q;
   assign LO_reg = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_muldiv
//  Purpose  : Directed self-checking bench for hilo_muldiv.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv;
   import hilo_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  Op = 3'd0;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic        busy;
   logic [31:0] HI_reg;
   logic [31:0] LO_reg;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   always #5 clk = ~clk;

   hilo_muldiv dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .Op      (Op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .HI_reg  (HI_reg),
      .LO_reg  (LO_reg)
   );

   // Present one request for one edge, then scramble operands
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      start   = 1'b1;
      Op      = op;
      rs_data = a;
      rt_data = b;
      @(posedge clk);
      #1;
      start   = 1'b0;
      Op      = 3'($urandom_range(0, 7));
      rs_data = $urandom;
      rt_data = $urandom;
   endtask

   // Count negedges with busy high; ends on a negedge with busy low (bounded)
   task automatic wait_done(output int n);
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      start   = 1'b1;
      Op      = OP_MTHI;
      rs_data = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (HI_reg !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", HI_reg); end
      checks++; if (LO_reg !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", LO_reg); end
      @(negedge clk);
      start  = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_move;
      issue(OP_MTHI, 32'h1111_1111, 32'hFFFF_FFFF);
      checks++; if (HI_reg !== 32'h1111_1111) begin errors++; $display("FAIL mthi_hi: got %h expected 11111111", HI_reg); end
      checks++; if (LO_reg !== 32'd0) begin errors++; $display("FAIL mthi_lo: got %h expected 00000000", LO_reg); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
      @(negedge clk);
      issue(OP_MTLO, 32'h2222_2222, 32'h0);
      checks++; if (LO_reg !== 32'h2222_2222) begin errors++; $display("FAIL mtlo_lo: got %h expected 22222222", LO_reg); end
      checks++; if (HI_reg !== 32'h1111_1111) begin errors++; $display("FAIL mtlo_hi: got %h expected 11111111", HI_reg); end
      @(negedge clk);
      issue(3'd6, 32'h3333_3333, 32'h4);
      @(negedge clk);
      issue(3'd7, 32'h4444_4444, 32'h4);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved_busy: got %b expected 0", busy); end
      checks++; if ({HI_reg, LO_reg} !== 64'h1111_1111_2222_2222) begin
         errors++; $display("FAIL reserved_hilo: got %h_%h expected 11111111_22222222", HI_reg, LO_reg);
      end
   endtask

   task automatic test_hold_during_run;
      int n;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (15) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", busy); end
      checks++; if ({HI_reg, LO_reg} !== 64'h1111_1111_2222_2222) begin
         errors++; $display("FAIL hold_hilo: got %h_%h expected 11111111_22222222", HI_reg, LO_reg);
      end
      wait_done(n);
      checks++; if ({HI_reg, LO_reg} !== 64'hFFFF_FFFE_0000_0001) begin
         errors++; $display("FAIL hold_result: got %h_%h expected fffffffe_00000001", HI_reg, LO_reg);
      end
   endtask

   task automatic test_back_to_back;
      vec_t v [14];
      int   n;
      v[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      v[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      v[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      v[3]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
      v[4]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      v[5]  = '{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0000};
      v[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      v[7]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
      v[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      v[9]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      v[10] = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
      v[11] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
      v[12] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
      v[13] = '{OP_DIV,   32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'hC000_0000};
      for (int i = 0; i < 14; i++) begin
         issue(v[i].op, v[i].a, v[i].b);
         wait_done(n);
         checks++; if (n !== 33) begin errors++; $display("FAIL vec%0d_busy_cycles: got %0d expected 33", i, n); end
         checks++; if (HI_reg !== v[i].hi) begin errors++; $display("FAIL vec%0d_hi: got %h expected %h", i, HI_reg, v[i].hi); end
         checks++; if (LO_reg !== v[i].lo) begin errors++; $display("FAIL vec%0d_lo: got %h expected %h", i, LO_reg, v[i].lo); end
      end
   endtask

   task automatic test_start_while_busy;
      int n;
      issue(OP_MULT, 32'h0000_0005, 32'h0000_0006);
      repeat (4) @(negedge clk);
      start   = 1'b1;
      Op      = OP_MTLO;
      rs_data = 32'h0000_AAAA;
      @(posedge clk);
      #1;
      start   = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignored_busy: got %b expected 1", busy); end
      checks++; if (LO_reg === 32'h0000_AAAA) begin errors++; $display("FAIL ignored_mtlo_early: got %h expected not 0000aaaa", LO_reg); end
      wait_done(n);
      checks++; if (LO_reg !== 32'd30) begin errors++; $display("FAIL ignored_lo: got %h expected 0000001e", LO_reg); end
      checks++; if (HI_reg !== 32'd0) begin errors++; $display("FAIL ignored_hi: got %h expected 00000000", HI_reg); end
   endtask

   task automatic test_reset_abort;
      logic busy_seen;
      issue(OP_MTHI, 32'h0000_0077, 32'h0);
      @(negedge clk);
      issue(OP_DIV, 32'h0000_0064, 32'h0000_0003);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if ({HI_reg, LO_reg} !== 64'd0) begin errors++; $display("FAIL abort_hilo: got %h_%h expected 0_0", HI_reg, LO_reg); end
      repeat (40) @(negedge clk);
      checks++; if ({HI_reg, LO_reg} !== 64'd0) begin errors++; $display("FAIL abort_no_partial: got %h_%h expected 0_0", HI_reg, LO_reg); end
      issue(OP_MTHI, 32'h0000_0055, 32'h0);
      checks++; if (HI_reg !== 32'h0000_0055) begin errors++; $display("FAIL abort_mthi: got %h expected 00000055", HI_reg); end
      busy_seen = busy;
      repeat (4) begin
         @(negedge clk);
         busy_seen = busy_seen | busy;
      end
      checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL abort_mthi_busy: got %b expected 0", busy_seen); end
   endtask

   initial begin
      test_reset;
      test_move;
      test_hold_during_run;
      test_back_to_back;
      test_start_while_busy;
      test_reset_abort;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  operation request; qualifies Op, rs_data and rt_data in the same cycle.
REQ-005 Op  input  3  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 are reserved and treated as no-op.
REQ-006 rs_data  input  32  multiplicand/dividend, or the MTHI/MTLO source.
REQ-007 rt_data  input  32  multiplier/divisor; ignored for MTHI/MTLO.
REQ-008 busy  output  1  high while a multiply or divide is in progress; the control unit stalls MFHI/MFLO and further HI/LO ops on it.
REQ-009 HI_reg  output  32  architectural HI register, driving the writeback selector directly.
REQ-010 LO_reg  output  32  architectural LO register, driving the writeback selector directly.

Function
REQ-011 The block SHALL accept start only when busy=0; start with busy=1 SHALL be ignored, with no effect on state or operands.
REQ-012 An accepted MTHI SHALL write rs_data to HI_reg at that same edge, leave LO_reg unchanged and never assert busy.
REQ-013 An accepted MTLO SHALL write rs_data to LO_reg at that same edge, leave HI_reg unchanged and never assert busy.
REQ-014 A reserved Op SHALL change nothing.
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-016 IDLE -> RUN SHALL occur on an accepted MULT/MULTU/DIV/DIVU, latching the operands, the op and their signs, and clearing a 5-bit iteration counter.
REQ-017 RUN SHALL perform one iteration per cycle for exactly 32 cycles, then go to FIN.
REQ-018 FIN SHALL last one cycle, apply the sign correction, write HI_reg/LO_reg and return to IDLE.
REQ-019 busy SHALL equal (state != IDLE), giving 33 cycles high per operation.
REQ-020 HI_reg/LO_reg SHALL update on the same edge that busy falls and hold their previous values throughout RUN.
REQ-021 Multiply SHALL use iterative shift-add on operand magnitudes (signed) or raw operands (unsigned), producing the 64-bit product {HI,LO}.
REQ-022 A signed product SHALL be negated in FIN when sign(rs) XOR sign(rt) = 1.
REQ-023 Divide SHALL use restoring division on magnitudes: LO = quotient, HI = remainder.
REQ-024 For signed divide, quotient sign = sign(rs) XOR sign(rt), and remainder sign = sign(rs).
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-026 Divide by zero (either signedness) SHALL complete with normal latency and give LO=0xFFFFFFFF, HI=rs_data (unmodified dividend).
REQ-027 Operand changes after acceptance SHALL have no effect on the result.

Reset
REQ-028 reset=1 SHALL force state=IDLE, busy=0, HI_reg=0, LO_reg=0 and clear the counter and operand registers, taking priority over start.
REQ-029 reset during RUN or FIN SHALL abort the operation with no partial result written.

Structure
REQ-030 The Op encoding enum and the iteration count constant (32) SHALL live in the shared CPU package, alongside the writeback-select encoding.
REQ-031 The block SHALL be a single module with no sub-module; multiply and divide share the 64-bit accumulator/remainder register and the counter.

Verification
REQ-032 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-034 DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU rs=7, rt=2 -> LO=3, HI=1.
REQ-035 DIVU rs=0x12345678, rt=0 -> LO=0xFFFFFFFF, HI=0x12345678.
REQ-036 Start MULT; at cycle 5 assert start with MTLO rs=0xAAAA -> ignored; final LO is the product, not 0xAAAA.
REQ-037 Assert reset at cycle 10 of DIV -> next cycle busy=0, HI=LO=0; then MTHI rs=0x55 -> HI=0x55 the next cycle, busy never rises.
